fbw_arbiter: RTL

//   Shares the frame-buffer write port (row store/swap, column write, frame swap) among N_REQ

---
 rtl/fbw_if.sv | 47 ++++
 rtl/fbw_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fbw_if.sv
// Frame-buffer write bus between N_REQ frame producers, the arbiter and the frame buffer.
// slave = arbiter view; master = producer/frame-buffer view (testbench side).
interface fbw_if #(
   parameter int N_REQ    = 2,
   parameter int N_ROWS   = 64,
   parameter int N_COLS   = 64,
   parameter int BITDEPTH = 24
);
   localparam int LOG_N_ROWS = $clog2(N_ROWS);
   localparam int LOG_N_COLS = $clog2(N_COLS);

   logic [N_REQ-1:0]                 req;
   logic [N_REQ-1:0]                 gnt;
   logic [N_REQ-1:0][LOG_N_ROWS-1:0] s_row_addr;
   logic [N_REQ-1:0]                 s_row_store;
   logic [N_REQ-1:0]                 s_row_swap;
   logic [N_REQ-1:0]                 s_row_rdy;
   logic [N_REQ-1:0][BITDEPTH-1:0]   s_data;
   logic [N_REQ-1:0][LOG_N_COLS-1:0] s_col_addr;
   logic [N_REQ-1:0]                 s_wren;
   logic [N_REQ-1:0]                 s_frame_swap;
   logic [N_REQ-1:0]                 s_frame_rdy;
   logic [LOG_N_ROWS-1:0]            m_row_addr;
   logic                             m_row_store;
   logic                             m_row_swap;
   logic                             m_row_rdy;
   logic [BITDEPTH-1:0]              m_data;
   logic [LOG_N_COLS-1:0]            m_col_addr;
   logic                             m_wren;
   logic                             m_frame_swap;
   logic                             m_frame_rdy;
   logic                             timeout_err;

   modport slave (
      input  req, s_row_addr, s_row_store, s_row_swap, s_data, s_col_addr, s_wren,
             s_frame_swap, m_row_rdy, m_frame_rdy,
      output gnt, s_row_rdy, s_frame_rdy, m_row_addr, m_row_store, m_row_swap, m_data,
             m_col_addr, m_wren, m_frame_swap, timeout_err
   );

   modport master (
      output req, s_row_addr, s_row_store, s_row_swap, s_data, s_col_addr, s_wren,
             s_frame_swap, m_row_rdy, m_frame_rdy,
      input  gnt, s_row_rdy, s_frame_rdy, m_row_addr, m_row_store, m_row_swap, m_data,
             m_col_addr, m_wren, m_frame_swap, timeout_err
   );
endinterface

// File: rtl/fbw_arbiter.sv
// Round-robin, frame-granular arbiter for the frame-buffer write port with a pass-through
// datapath from the current owner and an optional watchdog that reclaims a stalled port.
module fbw_arbiter #(
   parameter int N_REQ    = 2,
   parameter int N_ROWS   = 64,
   parameter int N_COLS   = 64,
   parameter int BITDEPTH = 24,
   parameter int TIMEOUT  = 0
) (
   input  logic  clk,
   input  logic  rst,
   fbw_if.slave  bus
);
   localparam int PW = $clog2(N_REQ);
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_MAX = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

   typedef enum logic {ST_IDLE, ST_OWN} state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic             started_q, started_d;
   logic [WW-1:0]    wdog_q, wdog_d;

   logic [PW:0]      scan_idx;
   logic             pick_vld;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    owner_nxt;
   logic             own, own_rs, own_rsw, own_wr, own_fs, activity, rel, rel_tmo;

   assign own      = (state_q == ST_OWN);
   assign own_rs   = bus.s_row_store[owner_q];
   assign own_rsw  = bus.s_row_swap[owner_q];
   assign own_wr   = bus.s_wren[owner_q];
   assign own_fs   = bus.s_frame_swap[owner_q];
   assign activity = own_rs | own_rsw | own_wr | own_fs | bus.m_row_rdy | bus.m_frame_rdy;
   assign owner_nxt = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

   // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      scan_idx = '0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         scan_idx = {1'b0, rr_ptr_q} + (PW + 1)'(i);
         if (scan_idx >= (PW + 1)'(N_REQ)) scan_idx = scan_idx - (PW + 1)'(N_REQ);
         if (bus.req[scan_idx[PW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      started_d = started_q;
      wdog_d    = wdog_q;
      rel       = 1'b0;
      rel_tmo   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d           = ST_OWN;
               gnt_d             = '0;
               gnt_d[pick_idx]   = 1'b1;
               owner_d           = pick_idx;
               started_d         = 1'b0;
               wdog_d            = '0;
            end
         end
         ST_OWN: begin
            if (own_rs) started_d = 1'b1;
            if (activity)               wdog_d = '0;
            else if (wdog_q != WD_MAX)  wdog_d = wdog_q + 1'b1;
            // A row store in the same cycle as the req drop counts as started: the frame runs on.
            if (own_fs) begin
               rel = 1'b1;
            end else if (!bus.req[owner_q] && !started_q && !own_rs) begin
               rel = 1'b1;
            end else if ((TIMEOUT != 0) && (wdog_q == WD_MAX)) begin
               rel     = 1'b1;
               rel_tmo = 1'b1;
            end
            if (rel) begin
               state_d   = ST_IDLE;
               gnt_d     = '0;
               rr_ptr_d  = owner_nxt;
               started_d = 1'b0;
               wdog_d    = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         started_q <= 1'b0;
         wdog_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         started_q <= started_d;
         wdog_q    <= wdog_d;
      end
   end

   always_comb begin
      bus.m_row_addr   = '0;
      bus.m_row_store  = 1'b0;
      bus.m_row_swap   = 1'b0;
      bus.m_data       = '0;
      bus.m_col_addr   = '0;
      bus.m_wren       = 1'b0;
      bus.m_frame_swap = 1'b0;
      if (own) begin
         bus.m_row_addr   = bus.s_row_addr[owner_q];
         bus.m_row_store  = own_rs;
         bus.m_row_swap   = own_rsw;
         bus.m_data       = bus.s_data[owner_q];
         bus.m_col_addr   = bus.s_col_addr[owner_q];
         bus.m_wren       = own_wr;
         bus.m_frame_swap = own_fs;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.timeout_err = rel_tmo;

   for (genvar i = 0; i < N_REQ; i++) begin : g_rdy
      assign bus.s_row_rdy[i]   = gnt_q[i] & bus.m_row_rdy;
      assign bus.s_frame_rdy[i] = gnt_q[i] & bus.m_frame_rdy;
   end
endmodule
